// File: rtl/_8bit_seq_mul.sv
// Unsigned 8x8 shift-add multiplier around a single ripple-carry adder; done pulses 8 cycles after start is accepted.
// No backpressure: start is ignored while busy, p holds its value until the next completion.

module rca8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] sum_o,
  output logic       c_o
);
  logic carry;

  // A single loop variable carries the ripple chain bit by bit.
  always_comb begin
    sum_o = '0;
    carry = c_i;
    for (int i = 0; i < 8; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end
endmodule

module _8bit_seq_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  m_q;
  logic [7:0]  acc_q;
  logic [7:0]  q_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] p_q;

  logic [7:0]  sum;
  logic        c_out;
  logic [15:0] step_d;

  rca8 u_add (
    .a_i   (acc_q),
    .b_i   (m_q),
    .c_i   (1'b0),
    .sum_o (sum),
    .c_o   (c_out)
  );

  // The carry-out becomes the new MSB so 0xFF*0xFF stays exact.
  always_comb begin
    step_d = {1'b0, acc_q, q_q[7:1]};
    if (q_q[0]) begin
      step_d = {c_out, sum, q_q[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= a;
            acc_q   <= '0;
            q_q     <= b;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= step_d[15:8];
          q_q   <= step_d[7:0];
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            p_q     <= step_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;
endmodule

// File: tb/tb__8bit_seq_mul.sv
// Scoreboard bench for _8bit_seq_mul: expected products queued at start, checked on each done pulse.
module tb__8bit_seq_mul;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  logic [15:0] sb[$];

  _8bit_seq_mul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  // Every done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      logic [15:0] exp_p;
      done_cnt++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: done=1 p=%h, no product expected", p);
      end else begin
        exp_p = sb.pop_front();
        if (p !== exp_p) begin
          miscompares++;
          $display("FAIL product: p=%h expected %h", p, exp_p);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: %b expected 0", done); end
    vectors++; if (p !== 16'h0000) begin miscompares++; $display("FAIL reset_p: %h expected 0000", p); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max();
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    sb.push_back(16'hFE01);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      vectors++;
      if (busy !== (k <= 9)) begin miscompares++; $display("FAIL max_busy: cycle %0d busy=%b expected %b", k, busy, (k <= 9)); end
      vectors++;
      if (done !== (k == 9)) begin miscompares++; $display("FAIL max_done: cycle %0d done=%b expected %b", k, done, (k == 9)); end
      if (k < 9) begin
        vectors++;
        if (p !== 16'h0000) begin miscompares++; $display("FAIL max_p_early: cycle %0d p=%h expected 0000", k, p); end
      end
    end
    vectors++;
    if (p !== 16'hFE01) begin miscompares++; $display("FAIL max_p_hold: p=%h expected fe01", p); end
  endtask

  task automatic test_small(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp_p);
    int lat = 0;
    start = 1'b1; a = av; b = bv;
    sb.push_back(exp_p);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done === 1'b1 && lat == 0) lat = k;
    end
    vectors++;
    if (lat != 9) begin miscompares++; $display("FAIL small_latency: done at cycle %0d expected 9", lat); end
    vectors++;
    if (p !== exp_p) begin miscompares++; $display("FAIL small_p: p=%h expected %h", p, exp_p); end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    int at = 0;
    start = 1'b1; a = 8'd3; b = 8'd5;
    sb.push_back(16'h000F);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (k == 3) begin a = 8'hFF; b = 8'hFF; end
      else if (k <= 9) begin a = 8'($urandom); b = 8'($urandom); end
      if (done === 1'b1) begin ndone++; at = k; end
    end
    vectors++;
    if (ndone != 1 || at != 9) begin miscompares++; $display("FAIL busy_ignore_done: %0d pulses last at %0d expected 1 at 9", ndone, at); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_ignore_idle: busy=%b expected 0", busy); end
    vectors++;
    if (p !== 16'h000F) begin miscompares++; $display("FAIL busy_ignore_p: p=%h expected 000f", p); end
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    start = 1'b1; a = 8'hA5; b = 8'h3C;
    sb.push_back(16'h26AC);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: %b expected 0", done); end
    vectors++; if (p !== 16'h0000) begin miscompares++; $display("FAIL midreset_p: %h expected 0000", p); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_quiet: cycle %0d done=%b busy=%b expected 0 0", k, done, busy); end
    end
    start = 1'b1; a = 8'd2; b = 8'd2;
    sb.push_back(16'h0004);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done === 1'b1 && lat == 0) lat = k;
    end
    vectors++;
    if (lat != 9) begin miscompares++; $display("FAIL midreset_restart: done at cycle %0d expected 9", lat); end
  endtask

  task automatic test_back_to_back();
    int t[$];
    start = 1'b1; a = 8'd7; b = 8'd9;
    sb.push_back(16'h003F);
    sb.push_back(16'h0100);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) begin a = 8'h10; b = 8'h10; end
      if (k == 11) start = 1'b0;
      if (done === 1'b1) t.push_back(k);
    end
    vectors++;
    if (t.size() != 2) begin
      miscompares++; $display("FAIL b2b_count: %0d pulses expected 2", t.size());
    end else begin
      vectors++;
      if (t[1] - t[0] != 10) begin miscompares++; $display("FAIL b2b_period: %0d cycles expected 10", t[1] - t[0]); end
    end
    vectors++;
    if (p !== 16'h0100) begin miscompares++; $display("FAIL b2b_p: p=%h expected 0100", p); end
  endtask

  task automatic test_random();
    logic [7:0] ca[4];
    logic [7:0] cb[4];
    int n = 1500;
    int d0 = done_cnt;
    ca[0] = 8'h00; cb[0] = 8'h00;
    ca[1] = 8'hFF; cb[1] = 8'h01;
    ca[2] = 8'h80; cb[2] = 8'h02;
    ca[3] = 8'hFE; cb[3] = 8'hFF;
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i < 4) begin a = ca[i]; b = cb[i]; end
      else begin a = 8'($urandom); b = 8'($urandom); end
      sb.push_back(16'(a) * 16'(b));
      repeat (10) @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if (done_cnt - d0 != n) begin miscompares++; $display("FAIL random_count: %0d dones expected %0d", done_cnt - d0, n); end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL random_drain: %0d products never produced", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_small(8'd13, 8'd11, 16'h008F);
    test_small(8'h00, 8'h5A, 16'h0000);
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
